ex_mem_lsu: RTL
===============

Name: ex_mem_lsu

Overview:
EX→MEM pipeline register combined with the load/store unit. It captures one instruction from EX and, for loads and stores, runs a request/grant/response transaction on the data-memory bus. It then presents the completed instruction to the MEM/WB register through the valid/allowin handshake (ex_mem_valid out, mem_allowin in). Non-memory instructions pass through in one cycle.

Parameters:
XLEN, 32, datapath/address width
RF_AW, 5, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ex_valid  in  1  EX holds a valid instruction
ex_allowin  out  1  block can accept from EX this cycle
ex_pc  in  XLEN  instruction PC
ex_inst  in  XLEN  instruction word
ex_req_rf  in  1  instruction writes RF
ex_rf_waddr  in  RF_AW  destination register
ex_alu_result  in  XLEN  ALU result / effective address
ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
ex_mem_size  in  2  00 byte, 01 half, 10 word
ex_load_unsigned  in  1  zero-extend load
ex_store_data  in  XLEN  rs2 store data
dmem_req  out  1  bus request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  byte address
dmem_wdata  out  XLEN  lane-replicated store data
dmem_wstrb  out  4  byte strobes
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  full aligned word
ex_mem_valid  out  1  result valid to MEM/WB
mem_allowin  in  1  MEM/WB accepts
mem_pc, mem_inst  out  XLEN  registered copies
mem_req_rf  out  1  registered copy
mem_rf_waddr  out  RF_AW  registered copy
mem_wb_data  out  XLEN  load result or ALU result
mem_misalign  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (rst_n low at posedge): ms_valid=0, FSM=IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, all mem_* outputs and dmem_addr/wdata=0, mem_misalign=0. Outputs are 0 combinationally while ms_valid=0.
- ms_ready_go = ms_valid & (op none | FSM==DONE). ex_allowin = !ms_valid | (ms_ready_go & mem_allowin). ex_mem_valid = ms_ready_go.
- Capture on ex_valid & ex_allowin: latch all ex_* fields and set ms_valid=1. Otherwise, if ms_ready_go & mem_allowin, clear ms_valid. Otherwise hold.
- Non-memory op: ex_mem_valid is high in the cycle after capture. mem_wb_data = alu_result.
- FSM states: IDLE, REQ, WAIT, DONE.
  - Capture of a load or store → REQ. dmem_req=1 in REQ with addr, we, wdata and wstrb stable until gnt.
  - REQ & gnt & store → DONE. REQ & gnt & load → WAIT.
  - WAIT & rvalid → DONE; the extended load data is latched into the result register. rvalid arrives no earlier than the cycle after gnt. rvalid outside WAIT is ignored.
  - DONE & mem_allowin → REQ if a new memory op is captured in the same cycle, else IDLE. DONE & !mem_allowin → hold DONE with all outputs stable.
- Minimum load latency: capture@N, req@N+1 (gnt same cycle), rvalid@N+2, ex_mem_valid@N+3. Minimum store latency: ex_mem_valid@N+2.
- Store lanes: byte: wdata = data[7:0]×4, wstrb = 1<<addr[1:0]. Half: wdata = data[15:0]×2, wstrb = addr[1] ? 1100 : 0011. Word: wstrb = 1111. Load and store keep dmem_addr = full byte address.
- Load extract: the byte/half is selected by addr[1:0]/addr[1], then sign- or zero-extended to XLEN.
- Store instructions force mem_req_rf=0 at the output regardless of the input.
- Reset mid-transaction: sync reset returns the FSM to IDLE and drops dmem_req immediately. A later stale rvalid is ignored.
- Back-to-back: release and capture in the same cycle give zero bubble.

Optional Feature:
Macro LSU_MISALIGN_CHK_EN.
- Defined: half with addr[0]=1 or word with addr[1:0]≠0 issues no bus request. FSM goes directly REQ→DONE, mem_req_rf=0, mem_misalign=1 while ex_mem_valid, mem_wb_data = faulting address.
- Undefined: the low address bits are ignored for lane selection (half uses addr[1], word uses all lanes), dmem_addr is forced aligned, and mem_misalign is tied 0.

Test Plan:
- Reset: hold rst_n=0 2 cycles with ex_valid=1 → ex_mem_valid=0, dmem_req=0, all mem_*=0, ex_allowin=1 after release.
- ALU op, alu_result=0x1234, waddr=5, mem_allowin=1 → ex_mem_valid 1 cycle after capture, mem_wb_data=0x1234, back-to-back ops every cycle.
- Signed byte load addr=0x103, rdata=0x80FF00AA → mem_wb_data=0xFFFFFF80. Unsigned gives 0x00000080.
- Store half addr=0x202, data=0xBEEF, gnt delayed 2 cycles → req/addr/wdata=0xBEEFBEEF/wstrb=1100 held 3 cycles, ex_mem_valid next cycle, mem_req_rf=0.
- Load done with mem_allowin=0 for 3 cycles → outputs stable, ex_allowin=0. Stray rvalid ignored. Then mem_allowin=1 → released.
- With LSU_MISALIGN_CHK_EN, word load addr=0x301 → no dmem_req, mem_misalign=1, mem_wb_data=0x301. Without it, dmem_addr=0x300.

Source files
------------

// File: rtl/ex_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_lsu
//  Description : EX->MEM pipeline register fused with the load/store unit.
//                Captures one instruction from EX, runs a req/gnt/rvalid
//                data-memory transaction for loads and stores, then hands
//                the finished instruction to MEM/WB via valid/allowin.
//                Optional misalignment trap: define LSU_MISALIGN_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_lsu #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // EX side
    input  logic             ex_valid,
    output logic             ex_allowin,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_inst,
    input  logic             ex_req_rf,
    input  logic [RF_AW-1:0] ex_rf_waddr,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [1:0]       ex_mem_op,
    input  logic [1:0]       ex_mem_size,
    input  logic             ex_load_unsigned,
    input  logic [XLEN-1:0]  ex_store_data,
    // data-memory bus
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    // MEM/WB side
    output logic             ex_mem_valid,
    input  logic             mem_allowin,
    output logic [XLEN-1:0]  mem_pc,
    output logic [XLEN-1:0]  mem_inst,
    output logic             mem_req_rf,
    output logic [RF_AW-1:0] mem_rf_waddr,
    output logic [XLEN-1:0]  mem_wb_data,
    output logic             mem_misalign
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_REQ    = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_STORE = 2'b10;

    localparam logic [1:0] c_SZ_BYTE  = 2'b00;
    localparam logic [1:0] c_SZ_HALF  = 2'b01;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_ms_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_inst;
    logic             r_req_rf;
    logic [RF_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]  r_addr;
    logic             r_is_load;
    logic             r_is_store;
    logic [1:0]       r_size;
    logic             r_load_unsigned;
    logic [XLEN-1:0]  r_store_data;
    logic [XLEN-1:0]  r_wb_data;
    logic             r_misalign;

    logic             w_ex_is_load;
    logic             w_ex_is_store;
    logic             w_ex_is_mem;
    logic             w_ex_misalign;
    logic             w_is_mem;
    logic             w_ready_go;
    logic             w_capture;
    logic             w_release;
    logic             w_dmem_req;
    logic [XLEN-1:0]  w_load_data;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;

    // Decode of the incoming operation; reserved op 11 behaves as no memory op.
    assign w_ex_is_load  = (ex_mem_op == c_OP_LOAD);
    assign w_ex_is_store = (ex_mem_op == c_OP_STORE);
    assign w_ex_is_mem   = w_ex_is_load | w_ex_is_store;

`ifdef LSU_MISALIGN_CHK_EN
    // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are never misaligned.
    assign w_ex_misalign = w_ex_is_mem &
                           (((ex_mem_size == c_SZ_HALF) & ex_alu_result[0]) |
                            (ex_mem_size[1] & (ex_alu_result[1:0] != 2'b00)));
`else
    assign w_ex_misalign = 1'b0;
`endif

    assign w_is_mem   = r_is_load | r_is_store;
    assign w_ready_go = r_ms_valid & (~w_is_mem | (r_state == c_S_DONE));
    assign w_release  = w_ready_go & mem_allowin;
    assign ex_allowin = ~r_ms_valid | w_release;
    assign w_capture  = ex_valid & ex_allowin;

    // Pipeline payload register: capture from EX, release to MEM/WB, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ms_valid      <= 1'b0;
            r_pc            <= '0;
            r_inst          <= '0;
            r_req_rf        <= 1'b0;
            r_rf_waddr      <= '0;
            r_addr          <= '0;
            r_is_load       <= 1'b0;
            r_is_store      <= 1'b0;
            r_size          <= 2'b00;
            r_load_unsigned <= 1'b0;
            r_store_data    <= '0;
            r_wb_data       <= '0;
            r_misalign      <= 1'b0;
        end else if (w_capture) begin
            r_ms_valid      <= 1'b1;
            r_pc            <= ex_pc;
            r_inst          <= ex_inst;
            r_req_rf        <= ex_req_rf;
            r_rf_waddr      <= ex_rf_waddr;
            r_addr          <= ex_alu_result;
            r_is_load       <= w_ex_is_load;
            r_is_store      <= w_ex_is_store;
            r_size          <= ex_mem_size;
            r_load_unsigned <= ex_load_unsigned;
            r_store_data    <= ex_store_data;
            // ALU result doubles as the faulting address on a misaligned trap.
            r_wb_data       <= ex_alu_result;
            r_misalign      <= w_ex_misalign;
        end else begin
            if (w_release) begin
                r_ms_valid <= 1'b0;
            end
            if ((r_state == c_S_WAIT) && dmem_rvalid) begin
                r_wb_data <= w_load_data;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a capture always restarts from the new instruction.
    always_comb begin
        w_state_nxt = r_state;
        if (w_capture) begin
            w_state_nxt = w_ex_is_mem ? c_S_REQ : c_S_IDLE;
        end else begin
            case (r_state)
                c_S_REQ: begin
                    if (r_misalign) begin
                        w_state_nxt = c_S_DONE;
                    end else if (dmem_gnt) begin
                        w_state_nxt = r_is_store ? c_S_DONE : c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (dmem_rvalid) begin
                        w_state_nxt = c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    if (mem_allowin) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    // Load extraction: pick the addressed byte/half, then sign/zero-extend.
    assign w_ld_byte = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_ld_half = dmem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dmem_rdata;
        if (r_size == c_SZ_BYTE) begin
            w_load_data = r_load_unsigned ? {{(XLEN-8){1'b0}}, w_ld_byte}
                                          : {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
        end else if (r_size == c_SZ_HALF) begin
            w_load_data = r_load_unsigned ? {{(XLEN-16){1'b0}}, w_ld_half}
                                          : {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
        end
    end

    // Bus drive: request only in REQ for an aligned access; fields zero otherwise.
    assign w_dmem_req = (r_state == c_S_REQ) & ~r_misalign;
    assign dmem_req   = w_dmem_req;

    always_comb begin
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = 4'b0000;
        if (w_dmem_req) begin
            dmem_we   = r_is_store;
`ifdef LSU_MISALIGN_CHK_EN
            dmem_addr = r_addr;
`else
            // Without the trap, low bits below the access size are dropped.
            if (r_size == c_SZ_BYTE) begin
                dmem_addr = r_addr;
            end else if (r_size == c_SZ_HALF) begin
                dmem_addr = {r_addr[XLEN-1:1], 1'b0};
            end else begin
                dmem_addr = {r_addr[XLEN-1:2], 2'b00};
            end
`endif
            if (r_is_store) begin
                if (r_size == c_SZ_BYTE) begin
                    dmem_wdata = {(XLEN/8){r_store_data[7:0]}};
                    dmem_wstrb = 4'b0001 << r_addr[1:0];
                end else if (r_size == c_SZ_HALF) begin
                    dmem_wdata = {(XLEN/16){r_store_data[15:0]}};
                    dmem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                end else begin
                    dmem_wdata = r_store_data;
                    dmem_wstrb = 4'b1111;
                end
            end
        end
    end

    // MEM/WB side outputs, forced to zero while the stage is empty.
    assign ex_mem_valid = w_ready_go;
    assign mem_pc       = r_ms_valid ? r_pc : '0;
    assign mem_inst     = r_ms_valid ? r_inst : '0;
    assign mem_rf_waddr = r_ms_valid ? r_rf_waddr : '0;
    assign mem_req_rf   = r_ms_valid & r_req_rf & ~r_is_store & ~r_misalign;
    assign mem_wb_data  = r_ms_valid ? r_wb_data : '0;

`ifdef LSU_MISALIGN_CHK_EN
    assign mem_misalign = w_ready_go & r_misalign;
`else
    assign mem_misalign = 1'b0;
`endif

endmodule
`default_nettype wire
